// File: rtl/iir_cascade.sv
// Cascade of NSEC direct-form-I biquads sharing one multiply-accumulate datapath,
// one section per clock, with ready/valid input, output saturation and sync clear.
module iir_cascade #(
    parameter int unsigned NB   = 12,
    parameter int unsigned NSEC = 2,
    parameter int unsigned CF   = NB - 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   vIn,
    input  logic [NB-1:0]          dIn,
    output logic                   rdy,
    input  logic [3*NB*NSEC-1:0]   b,
    input  logic [2*NB*NSEC-1:0]   a,
    output logic [NB-1:0]          dOut,
    output logic                   vOut
);

    localparam int unsigned PW = 2 * NB;
    localparam int unsigned AW = 2 * NB + 3;
    localparam int unsigned KW = (NSEC > 1) ? $clog2(NSEC) : 1;

    localparam logic signed [AW-1:0] SAT_MAX = AW'((2 ** (NB - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-(2 ** (NB - 1)));

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic signed [NB-1:0]  x_reg_q, x_reg_d;
    logic signed [NB-1:0]  dout_q, dout_d;
    logic                  vout_q, vout_d;

    logic signed [NB-1:0]  x1_q [NSEC];
    logic signed [NB-1:0]  x2_q [NSEC];
    logic signed [NB-1:0]  y1_q [NSEC];
    logic signed [NB-1:0]  y2_q [NSEC];
    logic signed [NB-1:0]  x1_d [NSEC];
    logic signed [NB-1:0]  x2_d [NSEC];
    logic signed [NB-1:0]  y1_d [NSEC];
    logic signed [NB-1:0]  y2_d [NSEC];

    logic signed [NB-1:0]  c_b0, c_b1, c_b2, c_a1, c_a2;
    logic signed [NB-1:0]  h_x1, h_x2, h_y1, h_y2;
    logic signed [PW-1:0]  p_b0, p_b1, p_b2, p_a1, p_a2;
    logic signed [AW-1:0]  acc_c, shr_c;
    logic signed [NB-1:0]  y_c;

    // Select coefficients and histories of the section currently being processed
    always_comb begin
        c_b0 = '0;
        c_b1 = '0;
        c_b2 = '0;
        c_a1 = '0;
        c_a2 = '0;
        h_x1 = '0;
        h_x2 = '0;
        h_y1 = '0;
        h_y2 = '0;
        for (int i = 0; i < int'(NSEC); i++) begin
            if (k_q == KW'(i)) begin
                c_b0 = b[3*NB*i        +: NB];
                c_b1 = b[3*NB*i + NB   +: NB];
                c_b2 = b[3*NB*i + 2*NB +: NB];
                c_a1 = a[2*NB*i        +: NB];
                c_a2 = a[2*NB*i + NB   +: NB];
                h_x1 = x1_q[i];
                h_x2 = x2_q[i];
                h_y1 = y1_q[i];
                h_y2 = y2_q[i];
            end
        end
    end

    // Full-precision products, wide accumulate, floor shift and clamp
    always_comb begin
        p_b0  = PW'(c_b0) * PW'(x_reg_q);
        p_b1  = PW'(c_b1) * PW'(h_x1);
        p_b2  = PW'(c_b2) * PW'(h_x2);
        p_a1  = PW'(c_a1) * PW'(h_y1);
        p_a2  = PW'(c_a2) * PW'(h_y2);
        acc_c = AW'(p_b0) + AW'(p_b1) + AW'(p_b2) - AW'(p_a1) - AW'(p_a2);
        shr_c = acc_c >>> CF;
        if (shr_c > SAT_MAX) begin
            y_c = NB'(SAT_MAX);
        end else if (shr_c < SAT_MIN) begin
            y_c = NB'(SAT_MIN);
        end else begin
            y_c = NB'(shr_c);
        end
    end

    // Next-state: sequencing, history shifts and output capture
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_reg_d = x_reg_q;
        dout_d  = dout_q;
        vout_d  = 1'b0;
        x1_d    = x1_q;
        x2_d    = x2_q;
        y1_d    = y1_q;
        y2_d    = y2_q;

        if (clr) begin
            state_d = IDLE;
            k_d     = '0;
            for (int i = 0; i < int'(NSEC); i++) begin
                x1_d[i] = '0;
                x2_d[i] = '0;
                y1_d[i] = '0;
                y2_d[i] = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (vIn) begin
                        x_reg_d = dIn;
                        k_d     = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < int'(NSEC); i++) begin
                        if (k_q == KW'(i)) begin
                            x2_d[i] = x1_q[i];
                            x1_d[i] = x_reg_q;
                            y2_d[i] = y1_q[i];
                            y1_d[i] = y_c;
                        end
                    end
                    x_reg_d = y_c;
                    if (k_q == KW'(NSEC - 1)) begin
                        dout_d  = y_c;
                        vout_d  = 1'b1;
                        k_d     = '0;
                        state_d = IDLE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            x_reg_q <= '0;
            dout_q  <= '0;
            vout_q  <= 1'b0;
            for (int i = 0; i < int'(NSEC); i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_reg_q <= x_reg_d;
            dout_q  <= dout_d;
            vout_q  <= vout_d;
            for (int i = 0; i < int'(NSEC); i++) begin
                x1_q[i] <= x1_d[i];
                x2_q[i] <= x2_d[i];
                y1_q[i] <= y1_d[i];
                y2_q[i] <= y2_d[i];
            end
        end
    end

    assign rdy  = (state_q == IDLE);
    assign dOut = dout_q;
    assign vOut = vout_q;

endmodule
